// File: rtl/instr_enc_pkg.sv
// Shared encodings and limits for the instruction encoder.
package instr_enc_pkg;

  typedef enum logic [1:0] {
    FMT_BR   = 2'b00,
    FMT_MEM  = 2'b01,
    FMT_REG  = 2'b10,
    FMT_BYTE = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10
  } err_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Branch offsets are halfword-scaled into 9 bits; memory offsets are 4 bits.
  localparam logic signed [15:0] BR_IMM_MIN  = -16'sd512;
  localparam logic signed [15:0] BR_IMM_MAX  = 16'sd510;
  localparam logic signed [15:0] MEM_IMM_MIN = -16'sd8;
  localparam logic signed [15:0] MEM_IMM_MAX = 16'sd7;

  localparam logic [15:0] PTR_STEP = 16'd2;

endpackage

// File: rtl/imm_pack.sv
// Combinational field packing and legality check for one encode request.
module imm_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [1:0]  fmt,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs,
  input  logic [3:0]  rt,
  input  logic [15:0] imm,
  output logic [15:0] instr,
  output logic        legal,
  output logic [1:0]  err_code
);

  logic signed [15:0] simm;
  err_e               err;

  assign simm = imm;

  // Pack fields by format; alignment is tested before range so it wins for branches.
  always_comb begin
    instr = '0;
    err   = ERR_NONE;
    case (fmt)
      FMT_BR: begin
        instr = {opcode, rd[2:0], imm[9:1]};
        if (imm[0])
          err = ERR_ALIGN;
        else if (simm < BR_IMM_MIN || simm > BR_IMM_MAX)
          err = ERR_RANGE;
      end
      FMT_MEM: begin
        instr = {opcode, rd, rs, imm[3:0]};
        if (simm < MEM_IMM_MIN || simm > MEM_IMM_MAX)
          err = ERR_RANGE;
      end
      FMT_REG: begin
        instr = {opcode, rd, rs, rt};
      end
      default: begin
        instr = {opcode, rd, imm[7:0]};
        if (imm[15:8] != 8'h00)
          err = ERR_RANGE;
      end
    endcase
  end

  assign legal    = (err == ERR_NONE);
  assign err_code = err;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one-word output buffer, write pointer and error reporting.
module instr_encoder
  import instr_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [1:0]  in_fmt,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rs,
  input  logic [3:0]  in_rt,
  input  logic [15:0] in_imm,
  input  logic        base_load,
  input  logic [15:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_addr,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count
);

  state_e      state, state_nxt;
  logic        accept, legal_acc, bad_acc;
  logic [15:0] pack_instr;
  logic        pack_legal;
  logic [1:0]  pack_err;
  logic [15:0] wr_ptr, base_word, slot_addr;

  imm_pack u_imm_pack (
    .opcode   (in_opcode),
    .fmt      (in_fmt),
    .rd       (in_rd),
    .rs       (in_rs),
    .rt       (in_rt),
    .imm      (in_imm),
    .instr    (pack_instr),
    .legal    (pack_legal),
    .err_code (pack_err)
  );

  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign legal_acc = accept & pack_legal;
  assign bad_acc   = accept & ~pack_legal;

  // A base load in the same cycle as an accept supplies that word's address.
  assign base_word = base_addr & 16'hFFFE;
  assign slot_addr = base_load ? base_word : wr_ptr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next state: stay full while a legal word replaces the one being drained.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (legal_acc)               state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !legal_acc) state_nxt = ST_EMPTY;
      default:                               state_nxt = ST_EMPTY;
    endcase
  end

  // FSM output.
  always_comb begin
    out_valid = (state == ST_FULL);
  end

  // Output word, address and write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr <= '0;
      out_addr  <= '0;
      wr_ptr    <= '0;
    end else if (legal_acc) begin
      out_instr <= pack_instr;
      out_addr  <= slot_addr;
      wr_ptr    <= slot_addr + PTR_STEP;
    end else if (base_load) begin
      wr_ptr    <= base_word;
    end
  end

  // Error pulse, sticky code and saturating count for dropped requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_code  <= '0;
      err_count <= '0;
    end else begin
      err_pulse <= bad_acc;
      if (bad_acc) begin
        err_code <= pack_err;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit, encode request present.
REQ-004 SHALL have port in_ready, output, 1 bit, request accepted this cycle when in_valid is also high.
REQ-005 SHALL have port in_opcode, input, 4 bits, opcode placed in instr[15:12].
REQ-006 SHALL have port in_fmt, input, 2 bits, format select: 00 branch, 01 memory, 10 register, 11 byte-load (LLB/LHB).
REQ-007 SHALL have ports in_rd, in_rs, in_rt, inputs, 4 bits each, register fields; in_rd[2:0] carries the branch condition ccc.
REQ-008 SHALL have port in_imm, input, 16 bits, byte-offset or immediate value, two's complement except for fmt 11.
REQ-009 SHALL have ports base_load (input, 1 bit) and base_addr (input, 16 bits), which load the write pointer.
REQ-010 SHALL have port out_valid, output, 1 bit, encoded word held.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream (instruction-memory writer) accepts.
REQ-012 SHALL have ports out_instr and out_addr, outputs, 16 bits each, giving the encoded word and its byte address.
REQ-013 SHALL have ports err_pulse (output, 1 bit), err_code (output, 2 bits: 01 range, 10 alignment) and err_count (output, 8 bits).

Function
REQ-014 SHALL drive in_ready = ~out_valid | out_ready combinationally; accept = in_valid & in_ready.
REQ-015 SHALL pack fmt 00 as {opcode, ccc, imm[9:1]}, so the decoder's sign-extend-then-shift-left-1 recovers imm.
REQ-016 SHALL pack fmt 01 as {opcode, rd, rs, imm[3:0]}, fmt 10 as {opcode, rd, rs, rt}, and fmt 11 as {opcode, rd, imm[7:0]}.
REQ-017 SHALL treat a request as legal only if: fmt 00 has imm[0]=0 and -512<=imm<=510; fmt 01 has -8<=imm<=7; fmt 11 has imm[15:8]=0; fmt 10 is always legal.
REQ-018 SHALL give a legal accept a latency of 1: on the next cycle out_valid=1 and out_instr/out_addr are registered.
REQ-019 SHALL drop an illegal accept: out_valid is unaffected, err_pulse is high for exactly one cycle on the next cycle, err_code is set, err_count increments and saturates at 255, and the pointer does not advance.
REQ-020 SHALL report alignment (10) when fmt 00 fails both the alignment and range checks.
REQ-021 SHALL hold all out_* signals stable while out_valid & ~out_ready.
REQ-022 SHALL use a two-state FSM: EMPTY->FULL on a legal accept; FULL->EMPTY on out_ready with no legal accept; FULL->FULL on out_ready with a legal accept (back-to-back, one word per cycle).
REQ-023 SHALL set out_addr to wr_ptr on a legal accept and then advance wr_ptr by 2, wrapping modulo 2^16 (0xFFFE->0x0000).
REQ-024 SHALL load wr_ptr with {base_addr[15:1],1'b0} on base_load.
REQ-025 SHALL, when base_load coincides with a legal accept, give the accepted word the loaded address, leaving wr_ptr at that address + 2.
REQ-026 SHALL apply base_load while FULL without altering the held out_addr.

Reset
REQ-027 SHALL, while rst_n is low, immediately clear out_valid, out_instr, out_addr, wr_ptr, err_pulse, err_code and err_count to 0 and set the FSM to EMPTY (in_ready=1).
REQ-028 SHALL discard a held word on reset mid-operation, with no output after reset is released.

Structure
REQ-029 SHALL define the format encodings, error codes and range limits (-512, 510, -8, 7) in a shared package instr_enc_pkg.
REQ-030 SHALL implement field packing and legality in one combinational sub-module, imm_pack; instr_encoder holds the FSM, pointer and error logic.

Verification
REQ-031 SHALL cover fmt 01, op 1000, rd 3, rs 2, imm -3 after reset -> next cycle out_instr 0x832D, out_addr 0x0000; following word at 0x0002.
REQ-032 SHALL cover fmt 00, op 1100, ccc 010, imm -4 -> 0xC5FE; imm 3 -> err_code 10, no out_valid; imm 512 -> err_code 01.
REQ-033 SHALL cover fmt 11, op 1010, rd 5, imm 0x00A7 -> 0xA5A7; imm 0x01A7 -> err_code 01, err_count +1; fmt 10 with 0,1,2,3 -> 0x0123.
REQ-034 SHALL cover out_ready low for 3 cycles with in_valid high -> in_ready 0, out_* stable; then out_ready high for 2 cycles -> two words transferred back-to-back.
REQ-035 SHALL cover base_load with base_addr 0xFFFF coinciding with an accept -> addresses 0xFFFE then 0x0000.
REQ-036 SHALL cover 300 illegal requests -> err_count holds at 255.
REQ-037 SHALL cover rst_n asserted while FULL -> all outputs 0 immediately.
